modul_seq: RTL and testbench

MODUL_SEQ -- requirements
Module: modul_seq

---
 rtl/modul_seq_pkg.sv | 21 ++
 rtl/modul_seq_if.sv | 32 +++
 rtl/modul_seq_cyc_cnt.sv | 30 +++
 rtl/modul_seq.sv | 146 ++++++++++++++
 tb/tb_modul_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/modul_seq_pkg.sv
// rtl/modul_seq_pkg.sv - shared constants and state encoding for the modulus sequencer
// Purpose: FSM state type, default timing parameters and bus widths used by
//          modul_seq, its interface and its wait counter.
// Ports:   none (package).
package modul_seq_pkg;

  localparam int OP_W        = 14;  // operand width (A, B)
  localparam int RES_W       = 24;  // modulus result width
  localparam int CNT_W       = 8;   // wait counter width
  localparam int TO_CYC_DEF  = 64;  // modulus-unit timeout
  localparam int CNV_CYC_DEF = 32;  // fixed BIN->DEC conversion wait

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MST   = 3'd1,
    MWAIT = 3'd2,
    CST   = 3'd3,
    CWAIT = 3'd4
  } state_t;

endpackage

// File: rtl/modul_seq_if.sv
// rtl/modul_seq_if.sv - handshake bundle between sequencer, modulus unit and converter
// Purpose: groups the modulus-unit and converter handshake signals.
// Signals: mod_A/mod_B  latched operands to the modulus unit
//          mod_st       one-cycle modulus start pulse
//          mod_ok/mod_Q modulus done strobe and result
//          cnv_st       one-cycle converter start pulse
//          cnv_BIN      captured result held for the converter
//          res_valid    one-cycle "converter output final" pulse
// Modports: master = sequencer side, slave = modulus unit / converter side.
interface modul_seq_if;
  import modul_seq_pkg::*;

  logic [OP_W-1:0]  mod_A;
  logic [OP_W-1:0]  mod_B;
  logic             mod_st;
  logic             mod_ok;
  logic [RES_W-1:0] mod_Q;
  logic             cnv_st;
  logic [RES_W-1:0] cnv_BIN;
  logic             res_valid;

  modport master (
    output mod_A, mod_B, mod_st, cnv_st, cnv_BIN, res_valid,
    input  mod_ok, mod_Q
  );

  modport slave (
    input  mod_A, mod_B, mod_st, cnv_st, cnv_BIN, res_valid,
    output mod_ok, mod_Q
  );

endinterface

// File: rtl/modul_seq_cyc_cnt.sv
// rtl/modul_seq_cyc_cnt.sv - saturating wait counter with clear and enable
// Purpose: counts enabled cycles, sticks at all-ones instead of wrapping.
// Ports:   clk    system clock
//          rst    synchronous active-high reset (count -> 0)
//          i_clr  synchronous clear, has priority over i_en
//          i_en   count enable
//          o_cnt  current count
module cyc_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/modul_seq.sv
// rtl/modul_seq.sv - 1 ms scheduled modulus + BIN->DEC conversion sequencer
// Purpose: on a 1 ms tick, when operands changed, a recompute is forced or the
//          previous result is stale, starts the modulus unit, waits for its
//          done strobe (with timeout), hands the result to the converter and
//          signals when the converted value is final.
// Ports:   clk, rst      clock and synchronous active-high reset
//          ce1ms         one-cycle scheduling tick
//          req           forced-recompute request (level)
//          A, B          binary operands (Re, Im)
//          bus           modul_seq_if master: modulus / converter handshakes
//          busy          high whenever the FSM is not IDLE
//          err           sticky modulus timeout flag
module modul_seq
  import modul_seq_pkg::*;
#(
  parameter int TO_CYC  = TO_CYC_DEF,
  parameter int CNV_CYC = CNV_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce1ms,
  input  logic            req,
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  modul_seq_if.master     bus,
  output logic            busy,
  output logic            err
);

  // Last count value of each wait phase; the counter starts at 0 in the
  // first wait cycle, so N cycles end when it reads N-1.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNV_LAST = CNT_W'(CNV_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_mod_A;
  logic [OP_W-1:0]  r_mod_B;
  logic [RES_W-1:0] r_cnv_BIN;
  logic             r_res_valid;
  logic             r_dirty;
  logic             r_err;

  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_start;
  logic             w_capture;
  logic             w_timeout;
  logic             w_cnv_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_capture  = 1'b0;
    w_timeout  = 1'b0;
    w_cnv_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ce1ms && (r_dirty || req || (A != r_mod_A) || (B != r_mod_B))) begin
          w_start = 1'b1;
          w_next  = MST;
        end
      end
      MST: w_next = MWAIT;
      MWAIT: begin
        // a done strobe in the last allowed cycle still counts as success
        if (bus.mod_ok) begin
          w_capture = 1'b1;
          w_next    = CST;
        end else if (w_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      CST: w_next = CWAIT;
      CWAIT: begin
        if (w_cnt == CNV_LAST) begin
          w_cnv_done = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_cnt_clr = (r_state == MST) || (r_state == CST);
  assign w_cnt_en  = (r_state == MWAIT) || (r_state == CWAIT);

  cyc_cnt #(
    .W(CNT_W)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mod_A     <= '0;
      r_mod_B     <= '0;
      r_cnv_BIN   <= '0;
      r_res_valid <= 1'b0;
      r_dirty     <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_res_valid <= w_cnv_done;
      if (w_start) begin
        r_mod_A <= A;
        r_mod_B <= B;
        r_dirty <= 1'b0;
        r_err   <= 1'b0;
      end
      if (w_capture) begin
        r_cnv_BIN <= bus.mod_Q;
      end
      // a timed-out result is stale: force a retry at the next tick
      if (w_timeout) begin
        r_err   <= 1'b1;
        r_dirty <= 1'b1;
      end
    end
  end

  // Pulses are masked while rst is high so a reset landing in MST/CST or on
  // the res_valid cycle issues nothing.
  assign bus.mod_st    = (r_state == MST) && !rst;
  assign bus.cnv_st    = (r_state == CST) && !rst;
  assign bus.res_valid = r_res_valid && !rst;
  assign bus.mod_A     = r_mod_A;
  assign bus.mod_B     = r_mod_B;
  assign bus.cnv_BIN   = r_cnv_BIN;
  assign busy          = (r_state != IDLE);
  assign err           = r_err;

endmodule

// File: tb/tb_modul_seq.sv
// tb/tb_modul_seq.sv - self-checking bench for modul_seq
module tb_modul_seq;
  import modul_seq_pkg::*;

  localparam int TO_CYC  = 64;
  localparam int CNV_CYC = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce1ms;
  logic            req;
  logic [OP_W-1:0] A;
  logic [OP_W-1:0] B;
  logic            busy;
  logic            err;

  modul_seq_if bus();

  modul_seq #(
    .TO_CYC  (TO_CYC),
    .CNV_CYC (CNV_CYC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ce1ms (ce1ms),
    .req   (req),
    .A     (A),
    .B     (B),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int lat   = 0;

  logic [OP_W-1:0]  m_A;
  logic [OP_W-1:0]  m_B;
  logic [RES_W-1:0] m_cnv;
  bit               m_dirty;
  bit               m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    lat++;
  endtask

  task automatic quiet();
    ce1ms      = 1'b0;
    req        = 1'b0;
    bus.mod_ok = 1'b0;
  endtask

  // activity that must be ignored while busy
  task automatic noise(input bit en, input bit stray);
    if (en) begin
      ce1ms = 1'($urandom);
      req   = 1'($urandom);
      A     = 14'($urandom);
      B     = 14'($urandom);
      if (stray) begin
        bus.mod_ok = 1'($urandom);
        bus.mod_Q  = 24'($urandom);
      end
    end else begin
      ce1ms = 1'b0;
      req   = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_A = '0; m_B = '0; m_cnv = '0; m_dirty = 1'b1; m_err = 1'b0;
  endtask

  // One tick in IDLE; k = MWAIT cycle with mod_ok (0 = never -> timeout).
  task automatic run_op(input logic [13:0] a, input logic [13:0] b, input bit rq,
                        input int k, input logic [23:0] q, input bit noisy, input bit poke);
    bit start;
    start = m_dirty || rq || (a != m_A) || (b != m_B);
    A = a; B = b; req = rq; ce1ms = 1'b1; bus.mod_ok = 1'b0;
    lat = 0;
    cyc();
    ce1ms = 1'b0; req = 1'b0;
    if (!start) begin
      chk("nostart_mod_st", 32'(bus.mod_st), 0);
      chk("nostart_busy",   32'(busy), 0);
      chk("nostart_mod_A",  32'(bus.mod_A), 32'(m_A));
      chk("nostart_err",    32'(err), 32'(m_err));
      return;
    end
    m_A = a; m_B = b; m_dirty = 1'b0; m_err = 1'b0;
    chk("mst_mod_st", 32'(bus.mod_st), 1);
    chk("mst_busy",   32'(busy), 1);
    chk("mst_mod_A",  32'(bus.mod_A), 32'(a));
    chk("mst_mod_B",  32'(bus.mod_B), 32'(b));
    chk("mst_err",    32'(err), 0);
    for (int j = 1; j <= TO_CYC; j++) begin
      noise(noisy, j == 1);
      cyc();
      chk("mwait_busy",   32'(busy), 1);
      chk("mwait_mod_st", 32'(bus.mod_st), 0);
      chk("mwait_cnv_st", 32'(bus.cnv_st), 0);
      chk("mwait_mod_A",  32'(bus.mod_A), 32'(m_A));
      bus.mod_ok = (j == k);
      bus.mod_Q  = (j == k) ? q : 24'($urandom);
      if (j == k) break;
    end
    noise(noisy, 1'b0);
    cyc();
    bus.mod_ok = 1'b0;
    if (k >= 1 && k <= TO_CYC) begin
      m_cnv = q;
      chk("cst_cnv_st",  32'(bus.cnv_st), 1);
      chk("cst_cnv_BIN", 32'(bus.cnv_BIN), 32'(q));
      chk("cst_lat",     32'(lat), 32'(k + 2));
      for (int c = 1; c <= CNV_CYC; c++) begin
        noise(noisy, 1'b1);
        if (poke && c == CNV_CYC / 2) begin
          A = 14'd100; ce1ms = 1'b1; req = 1'b1;
        end
        cyc();
        chk("cwait_cnv_st",  32'(bus.cnv_st), 0);
        chk("cwait_rv",      32'(bus.res_valid), 0);
        chk("cwait_busy",    32'(busy), 1);
        chk("cwait_cnv_BIN", 32'(bus.cnv_BIN), 32'(m_cnv));
        chk("cwait_mod_A",   32'(bus.mod_A), 32'(m_A));
      end
      quiet();
      cyc();
      chk("done_rv",      32'(bus.res_valid), 1);
      chk("done_busy",    32'(busy), 0);
      chk("done_err",     32'(err), 0);
      chk("done_latency", 32'(lat), 32'(1 + 1 + k + 1 + CNV_CYC));
      cyc();
      chk("after_rv", 32'(bus.res_valid), 0);
    end else begin
      quiet();
      m_err = 1'b1; m_dirty = 1'b1;
      chk("to_busy",    32'(busy), 0);
      chk("to_err",     32'(err), 1);
      chk("to_cnv_BIN", 32'(bus.cnv_BIN), 32'(m_cnv));
      chk("to_lat",     32'(lat), 32'(TO_CYC + 2));
      cyc();
      chk("to_err_sticky", 32'(err), 1);
    end
  endtask

  initial begin
    rst = 1'b1; ce1ms = 1'b0; req = 1'b0; A = '0; B = '0;
    bus.mod_ok = 1'b0; bus.mod_Q = '0;
    model_reset();
    cyc(); cyc();
    chk("rst_mod_A",  32'(bus.mod_A), 0);
    chk("rst_mod_B",  32'(bus.mod_B), 0);
    chk("rst_cnv",    32'(bus.cnv_BIN), 0);
    chk("rst_mod_st", 32'(bus.mod_st), 0);
    chk("rst_cnv_st", 32'(bus.cnv_st), 0);
    chk("rst_rv",     32'(bus.res_valid), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_err",    32'(err), 0);
    rst = 1'b0;
    A = 14'd3; B = 14'd4;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_no_tick_busy", 32'(busy), 0);
    end

    run_op(14'd3, 14'd4, 1'b0, 10, 24'd5, 1'b0, 1'b0);
    run_op(14'd3, 14'd4, 1'b0, 4, 24'd9, 1'b0, 1'b0);
    run_op(14'd3, 14'd4, 1'b1, int'($urandom_range(1, TO_CYC)), 24'($urandom), 1'b1, 1'b0);
    run_op(14'd5, 14'd6, 1'b0, 0, 24'd0, 1'b1, 1'b0);
    run_op(14'd5, 14'd6, 1'b0, 7, 24'($urandom), 1'b1, 1'b0);
    run_op(14'($urandom), 14'($urandom), 1'b1, TO_CYC, 24'($urandom), 1'b1, 1'b0);
    run_op(14'd1, 14'd2, 1'b1, 3, 24'($urandom), 1'b0, 1'b1);
    chk("poke_A_held", 32'(A), 100);
    run_op(14'd100, 14'd2, 1'b0, 4, 24'($urandom), 1'b0, 1'b0);
    chk("poke_mod_A", 32'(bus.mod_A), 100);

    for (int i = 0; i < 3; i++) begin
      bus.mod_ok = 1'b1; bus.mod_Q = 24'($urandom);
      cyc();
      chk("idle_stray_cnv",  32'(bus.cnv_BIN), 32'(m_cnv));
      chk("idle_stray_busy", 32'(busy), 0);
    end
    quiet();

    A = 14'd7; B = 14'd9; ce1ms = 1'b1;
    cyc();
    ce1ms = 1'b0;
    chk("mr_mod_st", 32'(bus.mod_st), 1);
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b1;
    #1;
    chk("mr_rst_mod_st", 32'(bus.mod_st), 0);
    chk("mr_rst_cnv_st", 32'(bus.cnv_st), 0);
    chk("mr_rst_rv",     32'(bus.res_valid), 0);
    cyc();
    model_reset();
    chk("mr_busy",  32'(busy), 0);
    chk("mr_mod_A", 32'(bus.mod_A), 0);
    chk("mr_mod_B", 32'(bus.mod_B), 0);
    chk("mr_cnv",   32'(bus.cnv_BIN), 0);
    chk("mr_err",   32'(err), 0);
    rst = 1'b0; bus.mod_ok = 1'b1; bus.mod_Q = 24'h123456;
    cyc();
    bus.mod_ok = 1'b0;
    chk("late_ok_busy",   32'(busy), 0);
    chk("late_ok_cnv_st", 32'(bus.cnv_st), 0);
    chk("late_ok_cnv",    32'(bus.cnv_BIN), 0);
    cyc();
    chk("late_ok_cnv_st2", 32'(bus.cnv_st), 0);

    run_op(14'd0, 14'd0, 1'b0, 3, 24'($urandom), 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [13:0] ra, rb;
      int rk;
      ra = ($urandom_range(0, 2) == 0) ? m_A : 14'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? m_B : 14'($urandom);
      rk = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO_CYC));
      run_op(ra, rb, 1'($urandom), rk, 24'($urandom), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
